// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// Group geometry (4-bit groups, at most 4 groups) and the legal-width check live here.
package pipelined_cla_adder_pkg;

    localparam int CLA_GROUP_BITS = 4;
    localparam int CLA_MAX_GROUPS = 4;

    // Group generate/propagate pair produced by one 4-bit lookahead group
    typedef struct packed {
        logic gg;
        logic pg;
    } group_gp_t;

    // Width must be a whole number of groups and fit in one level-2 unit
    function automatic bit cla_width_legal(input int width);
        return (width >= CLA_GROUP_BITS) &&
               (width % CLA_GROUP_BITS == 0) &&
               (width <= CLA_GROUP_BITS * CLA_MAX_GROUPS);
    endfunction

    // Group G*/P* from four bit-level g/p pairs
    function automatic group_gp_t group_gp(input logic [3:0] g, input logic [3:0] p);
        group_gp_t r;
        r.gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        r.pg = &p;
        return r;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// The ovf signal exists only when CLA_OVF_EN is defined.
interface pipelined_cla_adder_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_OVF_EN
    logic             ovf;

    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/pipelined_cla_adder_cla_group4.sv
// 4-bit carry-lookahead group: bit g/p plus carry-in -> carries into each bit, group G*/P*.
// Used both for intra-group carries and as the level-2 unit over group G*/P*.
module pipelined_cla_adder_cla_group4
    import pipelined_cla_adder_pkg::*;
(
    input  logic [3:0] g_i,
    input  logic [3:0] p_i,
    input  logic       c_i,
    output logic [3:0] c_o,     // c_o[k] = carry into position k (c_o[0] = c_i)
    output logic       gg_o,
    output logic       pg_o
);

    group_gp_t gp;

    assign c_o[0] = c_i;
    assign c_o[1] = g_i[0] | (p_i[0] & c_i);
    assign c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
    assign c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0]) |
                    (p_i[2] & p_i[1] & p_i[0] & c_i);

    assign gp   = group_gp(g_i, p_i);
    assign gg_o = gp.gg;
    assign pg_o = gp.pg;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready on both sides.
// S1 registers bit g/p, cin and group G*/P*; S2 resolves carries and registers sum/cout.
// Define CLA_OVF_EN to add the registered signed-overflow output.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic                  clk,
    input  logic                  rst,
    pipelined_cla_adder_if.slave  bus
);

    localparam int NUM_GROUPS = WIDTH / CLA_GROUP_BITS;

    if (!cla_width_legal(WIDTH)) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be 4, 8, 12 or 16");
    end

    // Handshake
    logic v1_q, v1_d;
    logic out_valid_q, out_valid_d;
    logic adv2, in_ready, accept;

    assign adv2     = v1_q & (~out_valid_q | bus.out_ready);
    assign in_ready = ~v1_q | adv2;
    assign accept   = bus.in_valid & in_ready;
    assign v1_d        = accept | (v1_q & ~adv2);
    assign out_valid_d = adv2 | (out_valid_q & ~bus.out_ready);

    // Stage 1 next values
    logic [WIDTH-1:0]      g_d, p_d;
    logic [NUM_GROUPS-1:0] gg_d, pg_d;

    assign g_d = bus.a & bus.b;
    assign p_d = bus.a ^ bus.b;

    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_s1_group
        group_gp_t gp;
        assign gp        = group_gp(g_d[4*gi +: 4], p_d[4*gi +: 4]);
        assign gg_d[gi]  = gp.gg;
        assign pg_d[gi]  = gp.pg;
    end

    // Stage 1 registers
    logic [WIDTH-1:0]      g_q, p_q;
    logic [NUM_GROUPS-1:0] gg_q, pg_q;
    logic                  cin_q;

    // S1: capture operands' g/p and group G*/P* only on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            g_q   <= '0;
            p_q   <= '0;
            gg_q  <= '0;
            pg_q  <= '0;
            cin_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            if (accept) begin
                g_q   <= g_d;
                p_q   <= p_d;
                gg_q  <= gg_d;
                pg_q  <= pg_d;
                cin_q <= bus.cin;
            end
        end
    end

    // Stage 2: level-2 lookahead over group G*/P*; absent groups are tied off
    logic [3:0] gg_pad, pg_pad;
    logic [3:0] grp_c;
    logic [4:0] grp_c_ext;
    logic       l2_gg, l2_pg;

    for (genvar gi = 0; gi < CLA_MAX_GROUPS; gi++) begin : g_pad
        if (gi < NUM_GROUPS) begin : g_used
            assign gg_pad[gi] = gg_q[gi];
            assign pg_pad[gi] = pg_q[gi];
        end else begin : g_tied
            assign gg_pad[gi] = 1'b0;
            assign pg_pad[gi] = 1'b0;
        end
    end

    pipelined_cla_adder_cla_group4 u_level2 (
        .g_i  (gg_pad),
        .p_i  (pg_pad),
        .c_i  (cin_q),
        .c_o  (grp_c),
        .gg_o (l2_gg),
        .pg_o (l2_pg)
    );

    // Carry into "group NUM_GROUPS" is the adder's carry-out
    assign grp_c_ext = {l2_gg | (l2_pg & cin_q), grp_c};

    logic [WIDTH-1:0] bit_c;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_s2_group
        logic unused_gg, unused_pg;
        pipelined_cla_adder_cla_group4 u_group (
            .g_i  (g_q[4*gi +: 4]),
            .p_i  (p_q[4*gi +: 4]),
            .c_i  (grp_c_ext[gi]),
            .c_o  (bit_c[4*gi +: 4]),
            .gg_o (unused_gg),
            .pg_o (unused_pg)
        );
    end

    assign sum_d  = p_q ^ bit_c;
    assign cout_d = grp_c_ext[NUM_GROUPS];

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // S2 output registers: load on advance, hold while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (adv2) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

`ifdef CLA_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into MSB differs from carry out of MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv2) begin
            ovf_q <= bit_c[WIDTH-1] ^ cout_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule
